// File: rtl/bist_scheduler.sv
// Round-robin scheduler sharing one BIST controller among NREQ requesters.
// Optional watchdog abort of stalled sessions: define BIST_SCHED_TIMEOUT_EN.
module bist_scheduler #(
  parameter int NREQ    = 4,
  parameter int SIG_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         pass,
  output logic                    bist_start,
  input  logic                    bist_end,
  input  logic [SIG_W-1:0]        sig,
  input  logic [NREQ*SIG_W-1:0]   golden,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t           state_r;
  logic [IDX_W-1:0] ptr_r;
  logic [IDX_W-1:0] idx_r;
  logic [IDX_W-1:0] sel_idx_s;
  logic [IDX_W-1:0] ptr_next_s;
  logic             req_any_s;
  logic             sig_match_s;
  logic             wd_hit_s;

  // Position reached by stepping off places from base, wrapping at NREQ.
  function automatic logic [IDX_W-1:0] rr_pos(input logic [IDX_W-1:0] base, input int off);
    int p;
    p = int'(base) + off;
    p = (p >= NREQ) ? p - NREQ : p;
    return IDX_W'(p);
  endfunction

  function automatic logic [NREQ-1:0] one_hot(input logic [IDX_W-1:0] i);
    logic [NREQ-1:0] v;
    v    = {NREQ{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  // Round-robin pick: scan downwards so the smallest offset from ptr wins.
  always_comb begin
    sel_idx_s = ptr_r;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sel_idx_s = req[rr_pos(ptr_r, k)] ? rr_pos(ptr_r, k) : sel_idx_s;
    end
  end

  assign req_any_s   = |req;
  assign ptr_next_s  = (idx_r == IDX_W'(NREQ - 1)) ? {IDX_W{1'b0}} : idx_r + 1'b1;
  assign sig_match_s = (sig == golden[int'(idx_r) * SIG_W +: SIG_W]);

`ifdef BIST_SCHED_TIMEOUT_EN
  localparam int WD_W = 16;

  logic [WD_W-1:0] wd_cnt_r;
  logic            timeout_err_r;

  assign wd_hit_s    = (wd_cnt_r == WD_W'(TIMEOUT - 1));
  assign timeout_err = timeout_err_r;

  // Watchdog: counts WAIT cycles of the current session; error flag is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_r      <= {WD_W{1'b0}};
      timeout_err_r <= 1'b0;
    end else begin
      if (state_r == START) begin
        wd_cnt_r <= {WD_W{1'b0}};
      end else if (state_r == WAIT) begin
        wd_cnt_r <= wd_cnt_r + 1'b1;
      end else begin
        wd_cnt_r <= wd_cnt_r;
      end
      if (state_r == WAIT && !bist_end && wd_hit_s) begin
        timeout_err_r <= 1'b1;
      end else begin
        timeout_err_r <= timeout_err_r;
      end
    end
  end
`else
  assign wd_hit_s    = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Session FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      ptr_r      <= {IDX_W{1'b0}};
      idx_r      <= {IDX_W{1'b0}};
      gnt        <= {NREQ{1'b0}};
      done       <= {NREQ{1'b0}};
      pass       <= {NREQ{1'b0}};
      bist_start <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= {NREQ{1'b0}};
          if (req_any_s) begin
            idx_r      <= sel_idx_s;
            gnt        <= one_hot(sel_idx_s);
            bist_start <= 1'b1;
            busy       <= 1'b1;
            state_r    <= START;
          end else begin
            gnt        <= {NREQ{1'b0}};
            bist_start <= 1'b0;
            busy       <= 1'b0;
            state_r    <= IDLE;
          end
        end
        START: begin
          bist_start <= 1'b0;
          state_r    <= WAIT;
        end
        WAIT: begin
          // A completion seen on the same edge as the watchdog limit still counts.
          if (bist_end) begin
            pass[idx_r] <= sig_match_s;
            done        <= one_hot(idx_r);
            state_r     <= CHECK;
          end else if (wd_hit_s) begin
            pass[idx_r] <= 1'b0;
            done        <= one_hot(idx_r);
            state_r     <= CHECK;
          end else begin
            state_r     <= WAIT;
          end
        end
        CHECK: begin
          done    <= {NREQ{1'b0}};
          gnt     <= {NREQ{1'b0}};
          busy    <= 1'b0;
          ptr_r   <= ptr_next_s;
          state_r <= IDLE;
        end
        default: begin
          gnt        <= {NREQ{1'b0}};
          done       <= {NREQ{1'b0}};
          bist_start <= 1'b0;
          busy       <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bist_scheduler.sv
// Self-checking bench for bist_scheduler: vector table plus reset/timeout sequences,
// with a scoreboard checking every done pulse against the expected result.
module tb_bist_scheduler;

  localparam int TB_TIMEOUT = 10;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  pass;
  logic        bist_start;
  logic        bist_end;
  logic [15:0] sig;
  logic [63:0] golden;
  logic        busy;
  logic        timeout_err;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [3:0]  req;
    logic [15:0] sig;
    int          dly;
    bit          drop;
    logic [3:0]  gnt;
    logic [3:0]  pass;
  } vec_t;

  typedef struct {
    logic [3:0] done;
    logic [3:0] pass;
    logic       te;
  } sb_t;

  sb_t  sb_q[$];
  vec_t vecs[14];

  bist_scheduler #(.NREQ(4), .SIG_W(16), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .gnt(gnt), .done(done), .pass(pass),
    .bist_start(bist_start), .bist_end(bist_end), .sig(sig), .golden(golden),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (gnt == 4'b0000 && n < 20);
  endtask

  // One full session, started with the DUT idle.
  task automatic run_session(input string nm, input logic [3:0] r, input logic [15:0] s,
                             input int d, input bit drop, input bit never_end,
                             input logic [3:0] eg, input logic [3:0] ep, input logic ete);
    int n;
    int t;
    int exp_t;
    sb_t e;
    req = r; sig = s; bist_end = 1'b0;
    wait_gnt(n);
    chk({nm, "_latency"}, n, 1);
    chk({nm, "_gnt"}, gnt, eg);
    chk({nm, "_start"}, bist_start, 1'b1);
    chk({nm, "_busy"}, busy, 1'b1);
    e.done = eg; e.pass = ep; e.te = ete;
    sb_q.push_back(e);
    exp_t = never_end ? TB_TIMEOUT + 1 : ((d == 0) ? 2 : d + 1);
    t = 0;
    if (!never_end && d == 0) bist_end = 1'b1;
    while (done == 4'b0000 && t < 40) begin
      @(posedge clk); #1;
      t++;
      if (t == 1) begin
        chk({nm, "_start_pulse"}, bist_start, 1'b0);
        chk({nm, "_gnt_hold"}, gnt, eg);
        if (drop) req = 4'b0000;
      end
      if (!never_end && d > 0 && t == d) bist_end = 1'b1;
    end
    chk({nm, "_cycles"}, t, exp_t);
    chk({nm, "_done"}, done, eg);
    chk({nm, "_pass"}, pass, ep);
    chk({nm, "_terr"}, timeout_err, ete);
    bist_end = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_done_clr"}, done, 4'b0000);
    chk({nm, "_gnt_clr"}, gnt, 4'b0000);
    chk({nm, "_idle"}, busy, 1'b0);
  endtask

  task automatic reset_checks(input string nm);
    chk({nm, "_gnt"}, gnt, 4'b0000);
    chk({nm, "_done"}, done, 4'b0000);
    chk({nm, "_pass"}, pass, 4'b0000);
    chk({nm, "_start"}, bist_start, 1'b0);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_terr"}, timeout_err, 1'b0);
  endtask

  // Scoreboard and grant invariants, sampled on the falling edge.
  always @(negedge clk) begin
    sb_t e;
    if (!reset) begin
      n_tests++;
      if (!$onehot0(gnt) || (!busy && gnt != 4'b0000)) begin
        n_fail++;
        $display("FAIL gnt_onehot: gnt=%b busy=%b required one-hot or zero, zero when idle", gnt, busy);
      end
      if (done != 4'b0000) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_done: done=%b required no pulse", done);
        end else begin
          e = sb_q.pop_front();
          if ({done, pass, timeout_err} !== {e.done, e.pass, e.te}) begin
            n_fail++;
            $display("FAIL sb_result: done=%b pass=%b terr=%b required done=%b pass=%b terr=%b",
                     done, pass, timeout_err, e.done, e.pass, e.te);
          end
        end
      end
    end
  end

  initial begin
    int n;
    golden   = {16'hBEEF, 16'h0F0F, 16'hA5A5, 16'h1234};
    reset    = 1'b1;
    req      = 4'b0000;
    bist_end = 1'b0;
    sig      = 16'h0000;

    //          req      sig       dly drop  gnt      pass
    vecs[0]  = '{4'b0010, 16'hA5A5, 5, 1'b0, 4'b0010, 4'b0010};
    vecs[1]  = '{4'b0001, 16'h0000, 2, 1'b0, 4'b0001, 4'b0010};
    vecs[2]  = '{4'b0100, 16'h0F0F, 0, 1'b0, 4'b0100, 4'b0110};
    vecs[3]  = '{4'b0011, 16'h1234, 1, 1'b0, 4'b0001, 4'b0111};
    vecs[4]  = '{4'b1000, 16'hBEEF, 1, 1'b0, 4'b1000, 4'b1111};
    vecs[5]  = '{4'b1111, 16'h1234, 1, 1'b0, 4'b0001, 4'b1111};
    vecs[6]  = '{4'b1111, 16'hA5A5, 3, 1'b0, 4'b0010, 4'b1111};
    vecs[7]  = '{4'b1111, 16'h0F0F, 1, 1'b0, 4'b0100, 4'b1111};
    vecs[8]  = '{4'b1111, 16'hBEEF, 1, 1'b0, 4'b1000, 4'b1111};
    vecs[9]  = '{4'b1111, 16'h1234, 1, 1'b0, 4'b0001, 4'b1111};
    vecs[10] = '{4'b1010, 16'h0000, 2, 1'b0, 4'b0010, 4'b1101};
    vecs[11] = '{4'b1001, 16'hBEEF, 1, 1'b0, 4'b1000, 4'b1101};
    vecs[12] = '{4'b0100, 16'h0000, 4, 1'b1, 4'b0100, 4'b1001};
    vecs[13] = '{4'b0101, 16'h0F0F, 1, 1'b0, 4'b0001, 4'b1000};

    repeat (2) @(posedge clk);
    #1;
    reset_checks("por");
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      run_session($sformatf("vec%0d", i), vecs[i].req, vecs[i].sig, vecs[i].dly,
                  vecs[i].drop, 1'b0, vecs[i].gnt, vecs[i].pass, 1'b0);
    end

    // Reset two cycles into WAIT: session aborts silently.
    req = 4'b0100; sig = 16'h0F0F; bist_end = 1'b0;
    wait_gnt(n);
    chk("abort_gnt", gnt, 4'b0100);
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    #1;
    reset_checks("abort_rst");
    req = 4'b0000;
    @(posedge clk); #1;
    reset = 1'b0;
    run_session("post_abort", 4'b1000, 16'hBEEF, 1, 1'b0, 1'b0, 4'b1000, 4'b1000, 1'b0);

    // Pointer must restart at 0 after reset even when it was elsewhere.
    run_session("ptr_set", 4'b0010, 16'hA5A5, 1, 1'b0, 1'b0, 4'b0010, 4'b1010, 1'b0);
    reset = 1'b1;
    #1;
    reset_checks("idle_rst");
    @(posedge clk); #1;
    reset = 1'b0;
    run_session("ptr_zero", 4'b1010, 16'hA5A5, 1, 1'b0, 1'b0, 4'b0010, 4'b0010, 1'b0);

`ifdef BIST_SCHED_TIMEOUT_EN
    run_session("wd_abort", 4'b0001, 16'h1234, 0, 1'b0, 1'b1, 4'b0001, 4'b0010, 1'b1);
    run_session("wd_sticky", 4'b0001, 16'h1234, 1, 1'b0, 1'b0, 4'b0001, 4'b0011, 1'b1);
    reset = 1'b1;
    #1;
    reset_checks("wd_rst");
    @(posedge clk); #1;
    reset = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
